mips_cpu: RTL and testbench
===========================

// Module: mips_cpu
// PURPOSE
//  Single-cycle 32-bit MIPS subset processor: PC, instruction ROM, register file, ALU, control, data RAM.
//  Top-level CPU of the design; only clock and reset come in, and there are no functional outputs.
//  Programs and data are preloaded by the bench via $readmemh into the memory arrays, so their
//  hierarchical names are fixed:
//   - instance mips_i_mem with array mem (instruction ROM)
//   - instance mips_d_mem with array mem (data RAM)
// PARAMETERS
//  IMEM_DEPTH  16  instruction ROM words; word-indexed by PC[5:2].
//  DMEM_DEPTH  32  data RAM words; word-indexed by ALU address [6:2].
// PORTS
//  clk  input  1  single clock; all state updates on rising edge.
//  rst  input  1  asynchronous, active-low reset.
//  Port order is (rst, clk) for positional instantiation.
// BEHAVIOUR
//  Reset (rst=0, asynchronous):
//   - PC=0 and registers $1..$31 = 0.
//   - Memory arrays are NOT cleared, so contents loaded during or after reset survive.
//  Timing:
//   - One instruction completes per rising clk; no pipeline, no stalls.
//   - Instruction fetch, register read, ALU and data-RAM read are combinational.
//   - Register file, data-RAM write and PC update are synchronous.
//  Memory arrays: reg [31:0] mem[0:DEPTH-1]. The ROM is read-only in hardware.
//  Address index bits above the depth are ignored, so addresses wrap.
//  Register file: 32x32. $0 always reads 0, and writes to it are discarded.
//  Supported instructions (all other opcode/funct values are NOPs: no register/RAM write, PC+=4):
//   - R-type (op 0x00): add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A; rd <= result.
//   - addi (0x08): rt <= rs + sext(imm16).
//   - lw (0x23): rt <= mem[rs+sext(imm)].
//   - sw (0x2B): mem[rs+sext(imm)] <= rt.
//   - beq (0x04): if rs==rt then PC <= PC+4+(sext(imm)<<2).
//   - j (0x02): PC <= {PC+4[31:28], addr26, 2'b00}.
//  Arithmetic: 32-bit two's complement, wrap on overflow, no exceptions.
//  slt is a signed compare that yields 1 or 0.
//  Next PC: default PC+4. A branch is taken only on beq equality; j has priority (mutually exclusive by opcode).
//  Read-after-write: a register written at edge N is visible to the instruction executing after edge N.
//  Reset mid-program: PC returns to 0 and registers clear immediately, without waiting for clk.
//  After reset releases, execution restarts from IROM word 0 with the existing memory contents.
// TESTING
//  1. Reset pulse low for 1 ns on negedge -> PC=0 and all registers 0 immediately, before any clk edge.
//  2. IROM[0]=addi $1,$0,5 (0x20010005); IROM[1]=addi $2,$1,-2 (0x2022FFFE)
//     -> after 2 clocks $1=5, $2=3.
//  3. DRAM[1]=0x0000000A; lw $3,4($0); add $4,$3,$3; sw $4,8($0)
//     -> $3=0xA, $4=0x14, DRAM[2]=0x14.
//  4. Branch test:
//     - beq $0,$0,+1 skips the next word; PC goes 0->8.
//     - beq $1,$0 with $1=5 is not taken; PC goes to PC+4.
//  5. j 0 at IROM[15] -> PC wraps back to 0.
//     An undefined opcode (0xFC000000) -> no state change except PC+4.
//  6. slt $5,$6,$7 with $6=0xFFFFFFFF, $7=1 -> $5=1.
//     addi $0,$0,7 -> $0 still reads 0.

Source files
------------

// File: rtl/mips_cpu.sv
// Single-cycle MIPS subset core: PC, instruction ROM, 32x32 register file, ALU and data RAM.
// Everything except the register file, PC and data RAM write is combinational.
module mips_imem #(
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic [AW-1:0] addr,
   output logic [31:0]   rdata
);
   logic [31:0] mem [0:DEPTH-1];

   assign rdata = mem[addr];
endmodule

module mips_dmem #(
   parameter int DEPTH = 32,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);
   logic [31:0] mem [0:DEPTH-1];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
   end

   assign rdata = mem[addr];
endmodule

module mips_cpu #(
   parameter int IMEM_DEPTH = 16,
   parameter int DMEM_DEPTH = 32
) (
   input logic rst,
   input logic clk
);
   localparam int IAW = $clog2(IMEM_DEPTH);
   localparam int DAW = $clog2(DMEM_DEPTH);

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_SLT   = 6'h2A;

   logic [31:0] pc_q, pc_d, pc_plus4;
   logic [31:0] rf_q [0:31];
   logic [31:0] instr;
   logic [5:0]  op, funct;
   logic [4:0]  rs, rt, rd;
   logic [31:0] rs_val, rt_val, imm_sext, alu_b, alu_y, dmem_rdata;
   logic        rf_we, dmem_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;

   mips_imem #(.DEPTH(IMEM_DEPTH)) mips_i_mem (
      .addr  (pc_q[IAW+1:2]),
      .rdata (instr)
   );

   assign op       = instr[31:26];
   assign rs       = instr[25:21];
   assign rt       = instr[20:16];
   assign rd       = instr[15:11];
   assign funct    = instr[5:0];
   assign imm_sext = {{16{instr[15]}}, instr[15:0]};
   assign rs_val   = (rs == 5'd0) ? 32'd0 : rf_q[rs];
   assign rt_val   = (rt == 5'd0) ? 32'd0 : rf_q[rt];
   assign alu_b    = (op == OP_RTYPE) ? rt_val : imm_sext;
   assign pc_plus4 = pc_q + 32'd4;

   always_comb begin
      alu_y = rs_val + alu_b;
      if (op == OP_RTYPE) begin
         case (funct)
            FN_SUB:  alu_y = rs_val - alu_b;
            FN_AND:  alu_y = rs_val & alu_b;
            FN_OR:   alu_y = rs_val | alu_b;
            FN_SLT:  alu_y = {31'd0, $signed(rs_val) < $signed(alu_b)};
            default: alu_y = rs_val + alu_b;
         endcase
      end
   end

   mips_dmem #(.DEPTH(DMEM_DEPTH)) mips_d_mem (
      .clk   (clk),
      .we    (dmem_we),
      .addr  (alu_y[DAW+1:2]),
      .wdata (rt_val),
      .rdata (dmem_rdata)
   );

   // Stores are suppressed while reset is held so a stale fetch cannot corrupt RAM.
   always_comb begin
      rf_we    = 1'b0;
      rf_waddr = rt;
      dmem_we  = 1'b0;
      pc_d     = pc_plus4;
      case (op)
         OP_RTYPE: begin
            rf_waddr = rd;
            rf_we    = funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
         end
         OP_ADDI, OP_LW: rf_we = 1'b1;
         OP_SW:          dmem_we = rst;
         OP_BEQ: begin
            if (rs_val == rt_val) pc_d = pc_plus4 + {imm_sext[29:0], 2'b00};
         end
         OP_J:           pc_d = {pc_plus4[31:28], instr[25:0], 2'b00};
         default: ;
      endcase
   end

   assign rf_wdata = (op == OP_LW) ? dmem_rdata : alu_y;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q <= 32'd0;
      end else begin
         pc_q <= pc_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
      end else if (rf_we && (rf_waddr != 5'd0)) begin
         rf_q[rf_waddr] <= rf_wdata;
      end
   end
endmodule

// File: tb/tb_mips_cpu.sv
// Bench for mips_cpu: directed programs plus random programs checked against an instruction-level model.
module tb_mips_cpu;
   logic clk = 1'b0;
   logic rst;
   int   n_pass  = 0;
   int   n_total = 0;

   localparam logic [31:0] HALT = 32'h1000FFFF;   // beq $0,$0,-1: spins in place

   logic [31:0] prog   [16];
   logic [31:0] m_imem [16];
   logic [31:0] m_rf   [32];
   logic [31:0] m_mem  [32];
   logic [31:0] m_pc;

   mips_cpu dut (.rst(rst), .clk(clk));

   always #5 clk = ~clk;

   task automatic fill_halt();
      for (int i = 0; i < 16; i++) prog[i] = HALT;
   endtask

   task automatic load_prog();
      for (int i = 0; i < 16; i++) begin
         dut.mips_i_mem.mem[i] = prog[i];
         m_imem[i]             = prog[i];
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      load_prog();
      m_pc = 32'd0;
      for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
      #1;
      rst = 1'b1;
   endtask

   // Instruction-set-level reference: one call retires one instruction.
   function automatic void model_step();
      logic [31:0] ins, a, b, se, ea, npc, res;
      logic [5:0]  opc, fn;
      logic [4:0]  dst;
      logic        wr;
      ins = m_imem[m_pc[5:2]];
      opc = ins[31:26];
      fn  = ins[5:0];
      a   = m_rf[ins[25:21]];
      b   = m_rf[ins[20:16]];
      se  = {{16{ins[15]}}, ins[15:0]};
      ea  = a + se;
      npc = m_pc + 32'd4;
      wr  = 1'b0;
      dst = ins[20:16];
      res = 32'd0;
      case (opc)
         6'h00: begin
            dst = ins[15:11];
            wr  = 1'b1;
            case (fn)
               6'h20:   res = a + b;
               6'h22:   res = a - b;
               6'h24:   res = a & b;
               6'h25:   res = a | b;
               6'h2A:   res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
               default: wr = 1'b0;
            endcase
         end
         6'h08: begin wr = 1'b1; res = ea; end
         6'h23: begin wr = 1'b1; res = m_mem[ea[6:2]]; end
         6'h2B: m_mem[ea[6:2]] = b;
         6'h04: if (a == b) npc = npc + (se << 2);
         6'h02: npc = {npc[31:28], ins[25:0], 2'b00};
         default: ;
      endcase
      if (wr && dst != 5'd0) m_rf[dst] = res;
      m_pc = npc;
   endfunction

   task automatic run_cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         model_step();
      end
      @(negedge clk);
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] s, t, d, fsel;
      logic [5:0]  fns [6];
      logic [5:0]  opx;
      fns  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h21};
      s    = $urandom_range(0, 7);
      t    = $urandom_range(0, 7);
      d    = $urandom_range(0, 7);
      fsel = $urandom_range(0, 5);
      case ($urandom_range(0, 9))
         0, 1: return {6'h00, s[4:0], t[4:0], d[4:0], 5'd0, fns[fsel]};
         2, 3: return {6'h08, s[4:0], t[4:0], 16'($urandom)};
         4:    return {6'h23, s[4:0], t[4:0], 16'($urandom_range(0, 255))};
         5:    return {6'h2B, s[4:0], t[4:0], 16'($urandom_range(0, 255))};
         6:    return {6'h04, s[4:0], t[4:0], 16'($urandom_range(0, 6) - 3)};
         7:    return {6'h02, 26'($urandom_range(0, 15))};
         8: begin
            opx = 6'($urandom);
            if (opx inside {6'h00, 6'h02, 6'h04, 6'h08, 6'h23, 6'h2B}) opx = 6'h3F;
            return {opx, 26'($urandom)};
         end
         default: return {6'h08, 5'd0, d[4:0], 16'($urandom_range(0, 300))};
      endcase
   endfunction

   task automatic test_reset();
      logic ok;
      rst = 1'b1;
      fill_halt();
      load_prog();
      #1 rst = 1'b0;
      #1;
      n_total++;
      if (dut.pc_q !== 32'd0) $display("FAIL reset_pc: got %h expected %h", dut.pc_q, 32'd0);
      else n_pass++;
      ok = 1'b1;
      for (int i = 0; i < 32; i++) if (dut.rf_q[i] !== 32'd0) ok = 1'b0;
      n_total++;
      if (!ok) $display("FAIL reset_regs: got nonzero register, expected all 0");
      else n_pass++;
   endtask

   task automatic test_clear_dmem();
      logic ok;
      fill_halt();
      prog[0] = 32'h20020080;   // addi $2,$0,128
      prog[1] = 32'hAC200000;   // sw $0,0($1)
      prog[2] = 32'h20210004;   // addi $1,$1,4
      prog[3] = 32'h10220001;   // beq $1,$2,+1
      prog[4] = 32'h08000001;   // j 1
      for (int i = 0; i < 32; i++) m_mem[i] = 32'd0;
      do_reset();
      run_cycles(140);
      ok = 1'b1;
      for (int i = 0; i < 32; i++) if (dut.mips_d_mem.mem[i] !== 32'd0) ok = 1'b0;
      n_total++;
      if (!ok) $display("FAIL clear_dmem: got nonzero word, expected all 0");
      else n_pass++;
   endtask

   task automatic test_addi();
      fill_halt();
      prog[0] = 32'h20010005;
      prog[1] = 32'h2022FFFE;
      do_reset();
      run_cycles(2);
      n_total++;
      if (dut.rf_q[1] !== 32'd5) $display("FAIL addi_r1: got %h expected %h", dut.rf_q[1], 32'd5);
      else n_pass++;
      n_total++;
      if (dut.rf_q[2] !== 32'd3) $display("FAIL addi_r2: got %h expected %h", dut.rf_q[2], 32'd3);
      else n_pass++;
      n_total++;
      if (dut.pc_q !== 32'd8) $display("FAIL addi_pc: got %h expected %h", dut.pc_q, 32'd8);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      logic ok;
      @(negedge clk);
      rst = 1'b0;
      m_pc = 32'd0;
      for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
      #1;
      n_total++;
      if (dut.pc_q !== 32'd0) $display("FAIL midreset_pc: got %h expected %h", dut.pc_q, 32'd0);
      else n_pass++;
      ok = 1'b1;
      for (int i = 0; i < 32; i++) if (dut.rf_q[i] !== 32'd0) ok = 1'b0;
      n_total++;
      if (!ok) $display("FAIL midreset_regs: got nonzero register, expected all 0");
      else n_pass++;
      rst = 1'b1;
      run_cycles(2);
      n_total++;
      if (dut.rf_q[2] !== 32'd3) $display("FAIL restart_r2: got %h expected %h", dut.rf_q[2], 32'd3);
      else n_pass++;
      n_total++;
      if (dut.pc_q !== 32'd8) $display("FAIL restart_pc: got %h expected %h", dut.pc_q, 32'd8);
      else n_pass++;
   endtask

   task automatic test_mem();
      fill_halt();
      prog[0] = 32'h2005000A;   // addi $5,$0,10
      prog[1] = 32'hAC050004;   // sw $5,4($0)
      prog[2] = 32'h8C030004;   // lw $3,4($0)
      prog[3] = 32'h00632020;   // add $4,$3,$3
      prog[4] = 32'hAC040008;   // sw $4,8($0)
      do_reset();
      run_cycles(5);
      n_total++;
      if (dut.rf_q[3] !== 32'hA) $display("FAIL lw_r3: got %h expected %h", dut.rf_q[3], 32'hA);
      else n_pass++;
      n_total++;
      if (dut.rf_q[4] !== 32'h14) $display("FAIL add_r4: got %h expected %h", dut.rf_q[4], 32'h14);
      else n_pass++;
      n_total++;
      if (dut.mips_d_mem.mem[2] !== 32'h14)
         $display("FAIL sw_dram2: got %h expected %h", dut.mips_d_mem.mem[2], 32'h14);
      else n_pass++;
   endtask

   task automatic test_branch();
      fill_halt();
      prog[0] = 32'h10000001;   // beq $0,$0,+1
      prog[1] = 32'h20090001;   // addi $9,$0,1 (skipped)
      prog[2] = 32'h20010005;   // addi $1,$0,5
      prog[3] = 32'h10200001;   // beq $1,$0,+1 (not taken)
      do_reset();
      run_cycles(1);
      n_total++;
      if (dut.pc_q !== 32'd8) $display("FAIL beq_taken_pc: got %h expected %h", dut.pc_q, 32'd8);
      else n_pass++;
      run_cycles(2);
      n_total++;
      if (dut.pc_q !== 32'd16) $display("FAIL beq_not_taken_pc: got %h expected %h", dut.pc_q, 32'd16);
      else n_pass++;
      n_total++;
      if (dut.rf_q[9] !== 32'd0) $display("FAIL beq_skip_r9: got %h expected %h", dut.rf_q[9], 32'd0);
      else n_pass++;
   endtask

   task automatic test_jump_nop();
      logic ok;
      for (int i = 0; i < 15; i++) prog[i] = 32'hFC000000;
      prog[15] = 32'h08000000;   // j 0
      do_reset();
      run_cycles(1);
      n_total++;
      if (dut.pc_q !== 32'd4) $display("FAIL nop_pc: got %h expected %h", dut.pc_q, 32'd4);
      else n_pass++;
      run_cycles(14);
      n_total++;
      if (dut.pc_q !== 32'd60) $display("FAIL nop_run_pc: got %h expected %h", dut.pc_q, 32'd60);
      else n_pass++;
      ok = 1'b1;
      for (int i = 0; i < 32; i++) if (dut.rf_q[i] !== 32'd0) ok = 1'b0;
      n_total++;
      if (!ok) $display("FAIL nop_regs: got nonzero register, expected all 0");
      else n_pass++;
      run_cycles(1);
      n_total++;
      if (dut.pc_q !== 32'd0) $display("FAIL jump_wrap_pc: got %h expected %h", dut.pc_q, 32'd0);
      else n_pass++;
   endtask

   task automatic test_slt_r0();
      fill_halt();
      prog[0] = 32'h2006FFFF;   // addi $6,$0,-1
      prog[1] = 32'h20070001;   // addi $7,$0,1
      prog[2] = 32'h00C7282A;   // slt $5,$6,$7
      prog[3] = 32'h20000007;   // addi $0,$0,7
      prog[4] = 32'h00E6402A;   // slt $8,$7,$6
      do_reset();
      run_cycles(5);
      n_total++;
      if (dut.rf_q[5] !== 32'd1) $display("FAIL slt_neg_r5: got %h expected %h", dut.rf_q[5], 32'd1);
      else n_pass++;
      n_total++;
      if (dut.rf_q[8] !== 32'd0) $display("FAIL slt_pos_r8: got %h expected %h", dut.rf_q[8], 32'd0);
      else n_pass++;
      n_total++;
      if (dut.rf_q[0] !== 32'd0) $display("FAIL r0_write: got %h expected %h", dut.rf_q[0], 32'd0);
      else n_pass++;
   endtask

   task automatic test_random();
      logic bad;
      for (int p = 0; p < 20; p++) begin
         for (int i = 0; i < 16; i++) prog[i] = rand_instr();
         do_reset();
         for (int c = 0; c < 40; c++) begin
            run_cycles(1);
            bad = 1'b0;
            n_total++;
            if (dut.pc_q !== m_pc) begin
               bad = 1'b1;
               $display("FAIL rand_pc p%0d c%0d: got %h expected %h", p, c, dut.pc_q, m_pc);
            end
            for (int i = 0; i < 32; i++) begin
               if (!bad && dut.rf_q[i] !== m_rf[i]) begin
                  bad = 1'b1;
                  $display("FAIL rand_reg p%0d c%0d r%0d: got %h expected %h", p, c, i, dut.rf_q[i], m_rf[i]);
               end
               if (!bad && dut.mips_d_mem.mem[i] !== m_mem[i]) begin
                  bad = 1'b1;
                  $display("FAIL rand_dram p%0d c%0d w%0d: got %h expected %h",
                           p, c, i, dut.mips_d_mem.mem[i], m_mem[i]);
               end
            end
            if (!bad) n_pass++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_clear_dmem();
      test_addi();
      test_reset_mid();
      test_mem();
      test_branch();
      test_jump_nop();
      test_slt_r0();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
